// File: rtl/fsm_pkg.sv
// Shared definitions for the serializer and the sequence-detector FSM family:
// state encodings, the common idle level, and a counter-width helper.
package fsm_pkg;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_SHIFT = 2'b01;
   localparam logic [1:0] S_GAP   = 2'b10;

   localparam bit IDLE_LEVEL_DEFAULT = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_SHIFT = S_SHIFT,
      ST_GAP   = S_GAP
   } state_t;

   // The gap counter holds GAP-1, so it never needs more than clog2(GAP) bits.
   function automatic int gap_count_width(input int gap);
      return (gap > 1) ? $clog2(gap) : 1;
   endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with a zero flag; it stops at zero rather than wrapping.
module down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         Resetn,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge Resetn) begin
      if (!Resetn) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/bit_pattern_serializer.sv
// Parallel-in, serial-out pattern source feeding the detector FSM's w input,
// with an optional idle gap and a one-cycle done pulse after every frame.
module bit_pattern_serializer
   import fsm_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int GAP        = 1,
   parameter bit IDLE_LEVEL = IDLE_LEVEL_DEFAULT,
   parameter bit MSB_FIRST  = 1'b1,
   localparam int LW        = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             Resetn,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LW-1:0]    load_len,
   output logic             w,
   output logic             w_valid,
   output logic             busy,
   output logic             done
);

   localparam int             GW       = gap_count_width(GAP);
   localparam logic [LW-1:0]  WIDTH_L  = LW'(WIDTH);
   localparam logic [GW-1:0]  GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] aligned;
   logic [LW-1:0]    eff_len;
   logic             take;
   logic             bit_zero;
   logic             gap_zero;

   assign load_ready = (state == ST_IDLE);
   assign busy       = ~load_ready;
   assign take       = load_valid & load_ready;

   // MSB-first frames are left-justified so bit L-1 always leaves from the top.
   always_comb begin
      eff_len = ((load_len == '0) || (load_len > WIDTH_L)) ? WIDTH_L : load_len;
      aligned = load_data;
      if (MSB_FIRST) begin
         aligned = load_data << (WIDTH_L - eff_len);
      end
   end

   // Holds the number of bits still to follow the one currently on w.
   down_counter #(.W(LW)) u_bit_cnt (
      .clk        (clk),
      .Resetn     (Resetn),
      .load       (take),
      .load_value (eff_len - LW'(1)),
      .dec        (state == ST_SHIFT),
      .zero       (bit_zero)
   );

   down_counter #(.W(GW)) u_gap_cnt (
      .clk        (clk),
      .Resetn     (Resetn),
      .load       ((state == ST_SHIFT) && bit_zero),
      .load_value (GAP_LOAD),
      .dec        (state == ST_GAP),
      .zero       (gap_zero)
   );

   always_ff @(posedge clk or negedge Resetn) begin
      if (!Resetn) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         w       <= IDLE_LEVEL;
         w_valid <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (take) begin
                  state   <= ST_SHIFT;
                  w       <= MSB_FIRST ? aligned[WIDTH-1] : aligned[0];
                  shreg   <= MSB_FIRST ? (aligned << 1) : (aligned >> 1);
                  w_valid <= 1'b1;
               end
            end
            ST_SHIFT: begin
               if (bit_zero) begin
                  w       <= IDLE_LEVEL;
                  w_valid <= 1'b0;
                  done    <= 1'b1;
                  state   <= (GAP > 0) ? ST_GAP : ST_IDLE;
               end else begin
                  w     <= MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
                  shreg <= MSB_FIRST ? (shreg << 1) : (shreg >> 1);
               end
            end
            ST_GAP: begin
               if (gap_zero) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/bit_pattern_serializer.md
Name: bit_pattern_serializer

Overview:
Upstream stimulus stage for the Moore/Mealy sequence-detector FSMs. It accepts a parallel bit pattern through a valid/ready handshake and shifts it out serially, one bit per clk, on w, which drives the detector's w input directly. An optional idle gap separates frames, and a one-cycle done pulse marks the end of each frame. The block replaces hand-written w sequences in benches and drives the detectors in on-board demos.

Parameters:
WIDTH, 16, maximum pattern length in bits (>=2)
GAP, 1, number of clk cycles w is held at IDLE_LEVEL after each frame (>=0)
IDLE_LEVEL, 0, value driven on w whenever no frame bit is being presented
MSB_FIRST, 1, 1: send bit len-1 down to bit 0; 0: send bit 0 up to bit len-1

Ports:
clk  in  1  rising-edge clock
Resetn  in  1  asynchronous active-low reset
load_valid  in  1  upstream offers a pattern
load_ready  out  1  block can accept a pattern this cycle
load_data  in  WIDTH  pattern bits
load_len  in  $clog2(WIDTH+1)  number of bits to send; 0 or >WIDTH means WIDTH
w  out  1  serial bit to the detector FSM, registered
w_valid  out  1  high while w carries a frame bit, registered
busy  out  1  high in SHIFT or GAP
done  out  1  one-cycle pulse after the last bit of a frame

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on Resetn. All state and all registered outputs clear the moment Resetn falls, independent of clk.
- Reset values: state=IDLE, w=IDLE_LEVEL, w_valid=0, done=0, busy=0, load_ready=1, shift register=0, bit and gap counters=0.
- States:
  - IDLE: load_ready=1. A handshake (load_valid & load_ready at posedge k) captures load_data and the effective length L, moves to SHIFT, and registers the first bit onto w with w_valid=1 at edge k.
  - SHIFT: one new bit on w at each of edges k..k+L-1, so w_valid is high for exactly L cycles.
    - At edge k+L: w=IDLE_LEVEL, w_valid=0, done=1 for one cycle.
    - The next state is GAP if GAP>0, otherwise IDLE.
  - GAP: w=IDLE_LEVEL for GAP cycles, then IDLE. load_ready stays low.
- load_ready is combinational from state (high only in IDLE). busy is the complement of (state==IDLE).
- Minimum frame period: L+GAP+1 cycles. With GAP=0 there is still one IDLE cycle between frames.
- Length rules: effective L = (load_len==0 || load_len>WIDTH) ? WIDTH : load_len.
  - MSB_FIRST=1: sends load_data[L-1] down to load_data[0]. Bits above L-1 are ignored.
  - MSB_FIRST=0: sends load_data[0] up to load_data[L-1].
- While busy, load_valid and load_data are ignored and never captured. Upstream must hold its request until load_ready is high.
- The detector samples w at the next posedge after it changes, so each bit is seen by the FSM for exactly one clock.
- Reset mid-frame: the frame is aborted immediately, no done pulse is issued, and the first handshake after release starts a fresh frame.
- L=1: w_valid is high for one cycle, and done follows on the next cycle.

Decomposition:
- A shared package fsm_pkg holds:
  - state localparams S_IDLE=2'b00, S_SHIFT=2'b01, S_GAP=2'b10;
  - a common IDLE_LEVEL default, reused by the detector FSM family.
- One sub-module, down_counter (parameterised width, load, decrement, zero flag), serves both the bit counter and the gap counter.
- The shift register and FSM stay in the top module.

Test Plan (WIDTH=8, GAP=2, MSB_FIRST=1, IDLE_LEVEL=0 unless stated):
1. Resetn=0 at an arbitrary point, no clk edge -> w=0, w_valid=0, done=0, busy=0, load_ready=1 immediately.
2. Load 8'b1011_0011, len=8 -> w=1,0,1,1,0,0,1,1 on 8 consecutive cycles with w_valid=1; then done=1 for one cycle; load_ready=1 again 3 cycles after the last bit.
3. Load 8'b0000_0101, len=3 -> w=1,0,1 with w_valid high for 3 cycles. Repeat with MSB_FIRST=0 and 8'b0000_0110 -> w=0,1,1.
4. Hold load_valid=1 with 8'hFF during the frame in test 2 -> no corruption of the first frame; 8'hFF starts only in the cycle after load_ready returns, for 8 ones in total.
5. Assert Resetn=0 after 4 bits of 8'hA5 -> w=0, w_valid=0, no done; after release, 8'h3C, len=8 is sent intact as 0,0,1,1,1,1,0,0.
6. Send len=0 and len=9 with 8'h81 -> both send 8 bits, 1,0,0,0,0,0,0,1. Send GAP=0 back-to-back frames -> exactly one IDLE cycle between them.
